// File: rtl/csr_hpm.sv
// Machine-mode hardware performance monitor CSRs: mcycle, minstret, mhpmcounterN,
// mhpmeventN and mcountinhibit. Define CSR_HPM_OVF_IRQ_EN to enable counter overflow interrupts.
module csr_hpm #(
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned CNT_WIDTH  = 40,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rden,
    input  logic [11:0]           raddr,
    output logic [31:0]           rdata,
    output logic                  rhit,
    input  logic                  wren,
    input  logic [11:0]           waddr,
    input  logic [31:0]           wdata,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  ovf_irq
);

    // Address of the register belonging to programmable counter index i (counter i+3).
    function automatic logic [11:0] hpm_addr(input logic [11:0] base, input int i);
        return base + 12'(i + 3);
    endfunction

    // Replace one 32-bit half of a counter; bits at or above CNT_WIDTH are dropped.
    function automatic logic [CNT_WIDTH-1:0] merge_half(input logic [CNT_WIDTH-1:0] cur,
                                                        input logic hi,
                                                        input logic [31:0] d);
        logic [63:0] t;
        t = 64'(cur);
        if (hi) t[63:32] = d;
        else    t[31:0]  = d;
        return t[CNT_WIDTH-1:0];
    endfunction

    logic [63:0]           mcycle_q, mcycle_d;
    logic [63:0]           minstret_q, minstret_d;
    logic [CNT_WIDTH-1:0]  hpm_cnt_q [NUM_HPM];
    logic [CNT_WIDTH-1:0]  hpm_cnt_d [NUM_HPM];
    logic [4:0]            sel_q [NUM_HPM];
    logic [4:0]            sel_d [NUM_HPM];
    logic                  inh_cy_q, inh_cy_d;
    logic                  inh_ir_q, inh_ir_d;
    logic [NUM_HPM-1:0]    inh_hpm_q, inh_hpm_d;

    logic [31:0]           ev_ext;
    logic [NUM_HPM-1:0]    hpm_inc;
    logic [NUM_HPM-1:0]    hpm_wr_lo;
    logic [NUM_HPM-1:0]    hpm_wr_hi;
    logic [NUM_HPM-1:0]    ev_wr;
    logic [NUM_HPM-1:0]    of_rd;
    logic [63:0]           hpm_ext [NUM_HPM];
    logic [31:0]           inh_vec;
    logic [31:0]           rd_data;
    logic                  rd_hit;

    // Bit 0 stands for selector 0, so ev_ext[sel] is the selected event and
    // selectors above NUM_EVENTS land on zero bits.
    assign ev_ext = 32'({events, 1'b0});

    always_comb begin
        inh_vec = '0;
        inh_vec[0] = inh_cy_q;
        inh_vec[2] = inh_ir_q;
        for (int i = 0; i < NUM_HPM; i++) begin
            inh_vec[3+i] = inh_hpm_q[i];
            hpm_ext[i]   = 64'(hpm_cnt_q[i]);
            hpm_inc[i]   = ev_ext[sel_q[i]] & ~inh_hpm_q[i];
            hpm_wr_lo[i] = wren && (waddr == hpm_addr(12'hB00, i));
            hpm_wr_hi[i] = wren && (waddr == hpm_addr(12'hB80, i));
            ev_wr[i]     = wren && (waddr == hpm_addr(12'h320, i));
        end
    end

    // Read decode
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        case (raddr)
            12'hB00: begin rd_data = mcycle_q[31:0];    rd_hit = 1'b1; end
            12'hB80: begin rd_data = mcycle_q[63:32];   rd_hit = 1'b1; end
            12'hB02: begin rd_data = minstret_q[31:0];  rd_hit = 1'b1; end
            12'hB82: begin rd_data = minstret_q[63:32]; rd_hit = 1'b1; end
            12'h320: begin rd_data = inh_vec;           rd_hit = 1'b1; end
            default: ;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
            if (raddr == hpm_addr(12'hB00, i)) begin
                rd_data = hpm_ext[i][31:0];
                rd_hit  = 1'b1;
            end
            if (raddr == hpm_addr(12'hB80, i)) begin
                rd_data = hpm_ext[i][63:32];
                rd_hit  = 1'b1;
            end
            if (raddr == hpm_addr(12'h320, i)) begin
                rd_data = {of_rd[i], 26'b0, sel_q[i]};
                rd_hit  = 1'b1;
            end
        end
    end

    assign rdata = rden ? rd_data : 32'b0;
    assign rhit  = rden & rd_hit & rst;

    // Next state: a CSR write to one half replaces that half only and suppresses the increment.
    always_comb begin
        mcycle_d = inh_cy_q ? mcycle_q : mcycle_q + 64'd1;
        if (wren && waddr == 12'hB00)      mcycle_d = {mcycle_q[63:32], wdata};
        else if (wren && waddr == 12'hB80) mcycle_d = {wdata, mcycle_q[31:0]};

        minstret_d = (retire && !inh_ir_q) ? minstret_q + 64'd1 : minstret_q;
        if (wren && waddr == 12'hB02)      minstret_d = {minstret_q[63:32], wdata};
        else if (wren && waddr == 12'hB82) minstret_d = {wdata, minstret_q[31:0]};

        inh_cy_d  = inh_cy_q;
        inh_ir_d  = inh_ir_q;
        inh_hpm_d = inh_hpm_q;
        if (wren && waddr == 12'h320) begin
            inh_cy_d  = wdata[0];
            inh_ir_d  = wdata[2];
            inh_hpm_d = wdata[3 +: NUM_HPM];
        end

        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_cnt_d[i] = hpm_inc[i] ? hpm_cnt_q[i] + CNT_WIDTH'(1) : hpm_cnt_q[i];
            if (hpm_wr_lo[i])      hpm_cnt_d[i] = merge_half(hpm_cnt_q[i], 1'b0, wdata);
            else if (hpm_wr_hi[i]) hpm_cnt_d[i] = merge_half(hpm_cnt_q[i], 1'b1, wdata);
            sel_d[i] = ev_wr[i] ? wdata[4:0] : sel_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            hpm_cnt_q  <= '{default: '0};
            sel_q      <= '{default: '0};
            inh_cy_q   <= 1'b0;
            inh_ir_q   <= 1'b0;
            inh_hpm_q  <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            hpm_cnt_q  <= hpm_cnt_d;
            sel_q      <= sel_d;
            inh_cy_q   <= inh_cy_d;
            inh_ir_q   <= inh_ir_d;
            inh_hpm_q  <= inh_hpm_d;
        end
    end

`ifdef CSR_HPM_OVF_IRQ_EN
    logic [NUM_HPM-1:0] of_q, of_d;
    logic               irq_q;

    // OF is sticky: set on a genuine wrap (not a write), cleared only by software.
    always_comb begin
        for (int i = 0; i < NUM_HPM; i++) begin
            of_d[i] = ev_wr[i] ? wdata[31] : of_q[i];
            if (hpm_inc[i] && (&hpm_cnt_q[i]) && !hpm_wr_lo[i] && !hpm_wr_hi[i]) of_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            of_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            of_q  <= of_d;
            irq_q <= |of_q;
        end
    end

    assign of_rd   = of_q;
    assign ovf_irq = irq_q & rst;
`else
    assign of_rd   = '0;
    assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm.sv
// Directed self-checking bench for csr_hpm (NUM_HPM=2, CNT_WIDTH=40, NUM_EVENTS=8).
module tb_csr_hpm;

    logic        clk;
    logic        rst;
    logic        rden;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        rhit;
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        retire;
    logic [7:0]  events;
    logic        ovf_irq;

    int n_cmp;
    int n_err;
    logic [31:0] d;
    logic        h;
    logic        irq_exp;
    logic [31:0] ev3_exp;

    csr_hpm #(
        .NUM_HPM   (2),
        .CNT_WIDTH (40),
        .NUM_EVENTS(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rden   (rden),
        .raddr  (raddr),
        .rdata  (rdata),
        .rhit   (rhit),
        .wren   (wren),
        .waddr  (waddr),
        .wdata  (wdata),
        .retire (retire),
        .events (events),
        .ovf_irq(ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Combinational read within the low clock phase.
    task automatic rd(input logic [11:0] a, output logic [31:0] dat, output logic hit);
        rden  = 1'b1;
        raddr = a;
        #1;
        dat  = rdata;
        hit  = rhit;
        rden = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] dat);
        wren  = 1'b1;
        waddr = a;
        wdata = dat;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic pulse_ev(input logic [7:0] e);
        events = e;
        @(negedge clk);
        events = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; rden = 1'b0; raddr = '0; wren = 1'b0; waddr = '0; wdata = '0;
        retire = 1'b0; events = '0;

        repeat (3) @(negedge clk);
        rd(12'hB00, d, h);
        check("rhit_in_reset", {63'b0, h}, 64'd0);
        check("irq_in_reset", {63'b0, ovf_irq}, 64'd0);

        // Release, then 10 idle cycles.
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rd(12'hB00, d, h);
        check("mcycle_10", {32'b0, d}, 64'd10);
        check("mcycle_hit", {63'b0, h}, 64'd1);
        rd(12'hB80, d, h);
        check("mcycleh_0", {32'b0, d}, 64'd0);
        rd(12'hB02, d, h);
        check("minstret_0", {32'b0, d}, 64'd0);

        rden = 1'b0; raddr = 12'hB00; #1;
        check("rden0_data", {32'b0, rdata}, 64'd0);
        check("rden0_hit", {63'b0, rhit}, 64'd0);

        // minstret counting and high-half write.
        repeat (3) begin retire = 1'b1; @(negedge clk); retire = 1'b0; end
        rd(12'hB02, d, h);
        check("minstret_3", {32'b0, d}, 64'd3);
        wr(12'hB82, 32'd5);
        rd(12'hB82, d, h);
        check("minstreth_5", {32'b0, d}, 64'd5);
        rd(12'hB02, d, h);
        check("minstret_lo_held", {32'b0, d}, 64'd3);

        // Inhibit write takes effect one cycle later.
        retire = 1'b1;
        wr(12'h320, 32'h4);
        @(negedge clk);
        retire = 1'b0;
        rd(12'hB02, d, h);
        check("minstret_inhibit", {32'b0, d}, 64'd4);
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, d, h);
        check("inhibit_mask", {32'b0, d}, 64'h1D);
        wr(12'h320, 32'h0);

        // Event selection and counter inhibit.
        wr(12'h323, 32'd2);
        rd(12'h323, d, h);
        check("event3_sel", {32'b0, d}, 64'd2);
        repeat (3) pulse_ev(8'h02);
        wr(12'h320, 32'h8);
        repeat (2) pulse_ev(8'h02);
        rd(12'hB03, d, h);
        check("hpm3_inhibited", {32'b0, d}, 64'd3);
        pulse_ev(8'hFF);
        rd(12'hB04, d, h);
        check("hpm4_sel0", {32'b0, d}, 64'd0);
        wr(12'h324, 32'd9);
        pulse_ev(8'hFF);
        rd(12'hB04, d, h);
        check("hpm4_sel9", {32'b0, d}, 64'd0);

        // Overflow at 2^40-1.
        wr(12'h320, 32'h0);
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        rd(12'hB83, d, h);
        check("hpm3h_ff", {32'b0, d}, 64'hFF);
        wr(12'hB84, 32'hFFFF_FFFF);
        rd(12'hB84, d, h);
        check("hpm4h_trunc", {32'b0, d}, 64'hFF);
        pulse_ev(8'h02);
        rd(12'hB03, d, h);
        check("hpm3_wrap_lo", {32'b0, d}, 64'd0);
        rd(12'hB83, d, h);
        check("hpm3_wrap_hi", {32'b0, d}, 64'd0);
        check("irq_lag", {63'b0, ovf_irq}, 64'd0);
        @(negedge clk);
`ifdef CSR_HPM_OVF_IRQ_EN
        irq_exp = 1'b1;
        ev3_exp = 32'h8000_0002;
`else
        irq_exp = 1'b0;
        ev3_exp = 32'h0000_0002;
`endif
        check("irq_after_wrap", {63'b0, ovf_irq}, {63'b0, irq_exp});
        rd(12'h323, d, h);
        check("event3_of", {32'b0, d}, {32'b0, ev3_exp});
        wr(12'h323, 32'd2);
        @(negedge clk);
        check("irq_cleared", {63'b0, ovf_irq}, 64'd0);
        rd(12'h323, d, h);
        check("event3_of_clr", {32'b0, d}, 64'd2);

        // Write wins over increment; 64-bit wrap of mcycle.
        wr(12'hB00, 32'h100);
        rd(12'hB00, d, h);
        check("mcycle_wr", {32'b0, d}, 64'h100);
        @(negedge clk);
        rd(12'hB00, d, h);
        check("mcycle_wr_inc", {32'b0, d}, 64'h101);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB80, d, h);
        check("mcycle_max_hi", {32'b0, d}, 64'hFFFF_FFFF);
        @(negedge clk);
        rd(12'hB00, d, h);
        check("mcycle_wrap_lo", {32'b0, d}, 64'd0);
        rd(12'hB80, d, h);
        check("mcycle_wrap_hi", {32'b0, d}, 64'd0);

        // Unimplemented addresses.
        rd(12'h7C0, d, h);
        check("r7c0_data", {32'b0, d}, 64'd0);
        check("r7c0_hit", {63'b0, h}, 64'd0);
        rd(12'h325, d, h);
        check("ev5_data", {32'b0, d}, 64'd0);
        check("ev5_hit", {63'b0, h}, 64'd0);
        rd(12'hB05, d, h);
        check("hpm5_hit", {63'b0, h}, 64'd0);
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd(12'h320, d, h);
        check("w7c0_inhibit", {32'b0, d}, 64'd0);
        rd(12'h323, d, h);
        check("w7c0_ev3", {32'b0, d}, 64'd2);
        rd(12'hB03, d, h);
        check("w7c0_hpm3", {32'b0, d}, 64'd0);
        rd(12'hB84, d, h);
        check("w7c0_hpm4h", {32'b0, d}, 64'hFF);
        rd(12'hB02, d, h);
        check("w7c0_minstret", {32'b0, d}, 64'd4);

        // Reset mid-count.
        wr(12'h320, 32'h4);
        events = 8'h02;
        retire = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(12'hB00, d, h);
        check("rst_mcycle", {32'b0, d}, 64'd0);
        check("rst_hit", {63'b0, h}, 64'd0);
        check("rst_irq", {63'b0, ovf_irq}, 64'd0);
        rst = 1'b1;
        events = '0;
        retire = 1'b0;
        rd(12'hB03, d, h);
        check("rst_hpm3", {32'b0, d}, 64'd0);
        rd(12'hB84, d, h);
        check("rst_hpm4h", {32'b0, d}, 64'd0);
        rd(12'h323, d, h);
        check("rst_ev3", {32'b0, d}, 64'd0);
        rd(12'h320, d, h);
        check("rst_inhibit", {32'b0, d}, 64'd0);
        rd(12'hB82, d, h);
        check("rst_minstreth", {32'b0, d}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_hpm.md
CSR_HPM -- requirements
Module: csr_hpm

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning number of programmable counters mhpmcounter3..(3+NUM_HPM-1), legal 1..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 40, meaning implemented bits of every counter, legal 33..64.
REQ-003 SHALL have parameter NUM_EVENTS, default 8, meaning width of the event input bus, legal 1..31.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, reset; reset rst, synchronous, active-low; clock clk.
REQ-006 SHALL have port rden, input, 1, read enable.
REQ-007 SHALL have port raddr, input, 12, read CSR address.
REQ-008 SHALL have port rdata, output, 32, read data.
REQ-009 SHALL have port rhit, output, 1, raddr maps to an implemented register.
REQ-010 SHALL have port wren, input, 1, write enable.
REQ-011 SHALL have port waddr, input, 12, write CSR address.
REQ-012 SHALL have port wdata, input, 32, write data.
REQ-013 SHALL have port retire, input, 1, one instruction retired this cycle.
REQ-014 SHALL have port events, input, NUM_EVENTS, one pulse per event per cycle, bit k is event k+1.
REQ-015 SHALL have port ovf_irq, output, 1, counter overflow interrupt request.

Function
REQ-016 SHALL map mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhpmcounterN/Nh 0xB00+N/0xB80+N, mhpmeventN 0x320+N, mcountinhibit 0x320.
REQ-017 SHALL return rdata combinationally in the same cycle; rdata=0 and rhit=0 when rden=0 or the address is unimplemented.
REQ-018 SHALL read counter bits at or above CNT_WIDTH as 0 and ignore writes to them; mcycle and minstret are always 64 bits.
REQ-019 SHALL implement mcountinhibit bits 0, 2 and 3..(3+NUM_HPM-1); all other bits read 0.
REQ-020 SHALL implement mhpmeventN[4:0] as the event selector; select 0 or greater than NUM_EVENTS never counts.
REQ-021 SHALL increment mcycle every cycle and minstret when retire=1, each unless its inhibit bit is set.
REQ-022 SHALL increment mhpmcounterN by 1 when events[sel-1]=1 and its inhibit bit is clear.
REQ-023 SHALL wrap a counter from 2^CNT_WIDTH-1 to 0 (mcycle/minstret at 2^64-1).
REQ-024 SHALL make a CSR write to a counter half take priority over that counter's increment in the same cycle; the other half is held, and no carry is applied.
REQ-025 SHALL make a written mcountinhibit value take effect from the next cycle.
REQ-026 SHALL perform a write to an unimplemented address as a no-op.

Reset
REQ-027 SHALL clear all counters, selectors, OF bits and mcountinhibit when rst=0 at a clk edge, including mid-count.
REQ-028 SHALL hold ovf_irq=0 and rhit=0 during reset; rdata follows REQ-017.

Configuration
REQ-029 SHALL, with CSR_HPM_OVF_IRQ_EN defined, set mhpmeventN[31] (OF) on mhpmcounterN wrap, hold it until software writes 0, and drive ovf_irq registered as the OR of all OF bits, one cycle after the wrap.
REQ-030 SHALL, with CSR_HPM_OVF_IRQ_EN undefined, read bit 31 as 0 and tie ovf_irq to 0.

Verification
REQ-031 SHALL cover: reset, then 10 cycles idle -> mcycle reads 10 (±read skew of 0), minstret 0, rhit=1.
REQ-032 SHALL cover: mhpmevent3=2, events[1] pulsed 5 times, mcountinhibit bit3 set after 3 -> mhpmcounter3 reads 3.
REQ-033 SHALL cover: CNT_WIDTH=40, write mhpmcounter3h=0xFF and mhpmcounter3=0xFFFFFFFF, then 1 event -> counter reads 0, mhpmcounter3h reads 0, ovf_irq=1 the next cycle (macro defined).
REQ-034 SHALL cover: write mcycle=0x100 in the same cycle an increment is due -> the next read is 0x100, then 0x101 on the following cycle.
REQ-035 SHALL cover: read 0x7C0 and mhpmevent5 with NUM_HPM=2 -> rdata=0, rhit=0; a write to 0x7C0 changes no state.
